// File: rtl/five_checker.sv
// five_checker: sequential five-in-a-row detector for a 16x16 board.
// Walks the four lines through the last stone, one cell per clock.
module five_checker #(
    parameter int WIN_LEN = 5
) (
    input  logic         Clck,
    input  logic         Reset,
    input  logic [511:0] board,
    input  logic         start,
    input  logic [3:0]   move_x,
    input  logic [3:0]   move_y,
    output logic         busy,
    output logic         done,
    output logic         win,
    output logic [1:0]   winner,
    output logic [3:0]   run_len
);

    typedef enum logic [2:0] {
        IDLE, LOAD, WALK_POS, WALK_NEG, EVAL, DONE
    } state_t;

    localparam logic [3:0] WinLen = 4'(WIN_LEN);

    state_t      state_q;
    logic [3:0]  org_x_q, org_y_q;
    logic [3:0]  cur_x_q, cur_y_q;
    logic [1:0]  color_q;
    logic [1:0]  dir_q;
    logic [2:0]  pcnt_q, ncnt_q;
    logic        skip_q;
    logic        busy_q, done_q, win_q;
    logic [1:0]  winner_q;
    logic [3:0]  run_len_q;

    logic [4:0]  dx, dy, bx, by;
    logic [4:0]  cand_x, cand_y;
    logic [8:0]  cand_idx, org_idx;
    logic [1:0]  cand_cell, org_cell;
    logic [2:0]  cnt;
    logic        neg, in_rng, step_ok;
    logic [3:0]  len;

    // Candidate cell for the current walk step and the run length so far
    always_comb begin
        bx = 5'd0;
        by = 5'd0;
        unique case (dir_q)
            2'd0: begin bx = 5'd1; by = 5'd0;  end
            2'd1: begin bx = 5'd0; by = 5'd1;  end
            2'd2: begin bx = 5'd1; by = 5'd1;  end
            2'd3: begin bx = 5'd1; by = 5'h1f; end
        endcase
        neg       = (state_q == WALK_NEG);
        dx        = neg ? 5'd0 - bx : bx;
        dy        = neg ? 5'd0 - by : by;
        cand_x    = {1'b0, cur_x_q} + dx;
        cand_y    = {1'b0, cur_y_q} + dy;
        in_rng    = !cand_x[4] && !cand_y[4];
        cand_idx  = {cand_y[3:0], cand_x[3:0], 1'b0};
        org_idx   = {org_y_q, org_x_q, 1'b0};
        cand_cell = board[cand_idx +: 2];
        org_cell  = board[org_idx +: 2];
        cnt       = neg ? ncnt_q : pcnt_q;
        step_ok   = in_rng && (cand_cell == color_q) && (cnt < 3'd4);
        len       = 4'd1 + {1'b0, pcnt_q} + {1'b0, ncnt_q};
    end

    // Scan FSM with registered status outputs
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            org_x_q   <= '0;
            org_y_q   <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            color_q   <= '0;
            dir_q     <= '0;
            pcnt_q    <= '0;
            ncnt_q    <= '0;
            skip_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            winner_q  <= '0;
            run_len_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        org_x_q   <= move_x;
                        org_y_q   <= move_y;
                        win_q     <= 1'b0;
                        winner_q  <= '0;
                        run_len_q <= '0;
                        skip_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                LOAD: begin
                    color_q <= org_cell;
                    cur_x_q <= org_x_q;
                    cur_y_q <= org_y_q;
                    pcnt_q  <= '0;
                    dir_q   <= '0;
                    // Non-player cell: one pass-through cycle, no walk
                    if (org_cell == 2'b00 || org_cell == 2'b11) begin
                        skip_q  <= 1'b1;
                        state_q <= EVAL;
                    end else begin
                        run_len_q <= 4'd1;
                        state_q   <= WALK_POS;
                    end
                end
                WALK_POS: begin
                    if (step_ok) begin
                        pcnt_q  <= pcnt_q + 3'd1;
                        cur_x_q <= cand_x[3:0];
                        cur_y_q <= cand_y[3:0];
                    end else begin
                        cur_x_q <= org_x_q;
                        cur_y_q <= org_y_q;
                        ncnt_q  <= '0;
                        state_q <= WALK_NEG;
                    end
                end
                WALK_NEG: begin
                    if (step_ok) begin
                        ncnt_q  <= ncnt_q + 3'd1;
                        cur_x_q <= cand_x[3:0];
                        cur_y_q <= cand_y[3:0];
                    end else begin
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (skip_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        if (len > run_len_q) run_len_q <= len;
                        if (len >= WinLen) begin
                            win_q    <= 1'b1;
                            winner_q <= color_q;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else if (dir_q != 2'd3) begin
                            dir_q   <= dir_q + 2'd1;
                            cur_x_q <= org_x_q;
                            cur_y_q <= org_y_q;
                            pcnt_q  <= '0;
                            state_q <= WALK_POS;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign win     = win_q;
    assign winner  = winner_q;
    assign run_len = run_len_q;

endmodule

// File: tb/tb_five_checker.sv
// tb_five_checker: scoreboard bench for five_checker.
// Stimulus pushes expected results; a monitor pops on done.
module tb_five_checker;

    logic         Clck;
    logic         Reset;
    logic [511:0] board;
    logic         start;
    logic [3:0]   move_x, move_y;
    logic         busy, done, win;
    logic [1:0]   winner;
    logic [3:0]   run_len;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic       win;
        logic [1:0] winner;
        logic [3:0] run_len;
        int         lat;
        int         t0;
    } exp_t;

    exp_t sbq[$];

    five_checker #(.WIN_LEN(5)) dut (
        .Clck    (Clck),
        .Reset   (Reset),
        .board   (board),
        .start   (start),
        .move_x  (move_x),
        .move_y  (move_y),
        .busy    (busy),
        .done    (done),
        .win     (win),
        .winner  (winner),
        .run_len (run_len)
    );

    initial begin
        Clck = 1'b0;
        forever #5 Clck = ~Clck;
    end

    always @(posedge Clck) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: compare each done pulse with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge Clck);
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("win", 32'(win), 32'(e.win));
                    check("winner", 32'(winner), 32'(e.winner));
                    check("run_len", 32'(run_len), 32'(e.run_len));
                    check("latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic set_cell(input int x, input int y, input logic [1:0] c);
        board[x*2 + y*32 +: 2] = c;
    endtask

    // Issue a start; optionally queue the expected result
    task automatic go(input int x, input int y, input bit push,
                      input logic ew, input logic [1:0] ewn,
                      input logic [3:0] erl, input int elat);
        exp_t e;
        start  = 1'b1;
        move_x = 4'(x);
        move_y = 4'(y);
        e.win = ew; e.winner = ewn; e.run_len = erl;
        e.lat = elat; e.t0 = cyc + 1;
        if (push) sbq.push_back(e);
        @(posedge Clck);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clck);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got busy=1 expected busy=0 within 100 cycles");
        end
    endtask

    initial begin
        Reset  = 1'b1;
        board  = '0;
        start  = 1'b0;
        move_x = '0;
        move_y = '0;
        repeat (3) @(posedge Clck);
        #1;
        Reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_win", 32'(win), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_run_len", 32'(run_len), 32'd0);
        @(posedge Clck);
        #1;

        // Horizontal win mid-board
        for (int x = 3; x <= 7; x++) set_cell(x, 7, 2'b01);
        go(5, 7, 1'b1, 1'b1, 2'b01, 4'd5, 8);
        wait_idle();

        // Isolated stone in the corner
        board = '0;
        set_cell(0, 0, 2'b10);
        go(0, 0, 1'b1, 1'b0, 2'b00, 4'd1, 13);
        wait_idle();

        // Anti-diagonal from the right edge
        board = '0;
        for (int k = 0; k < 5; k++) set_cell(15 - k, k, 2'b10);
        go(15, 0, 1'b1, 1'b1, 2'b10, 4'd5, 17);
        wait_idle();

        // Near-miss of four, then back-to-back empty cell
        board = '0;
        for (int x = 0; x < 4; x++) set_cell(x, 15, 2'b01);
        go(0, 15, 1'b1, 1'b0, 2'b00, 4'd4, 16);
        wait_idle();
        go(9, 9, 1'b1, 1'b0, 2'b00, 4'd0, 2);
        wait_idle();

        // Second start during a scan is dropped
        board = '0;
        for (int x = 3; x <= 7; x++) set_cell(x, 7, 2'b01);
        go(5, 7, 1'b1, 1'b1, 2'b01, 4'd5, 8);
        repeat (2) @(posedge Clck);
        #1;
        start  = 1'b1;
        move_x = 4'd9;
        move_y = 4'd9;
        @(posedge Clck);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (4) @(posedge Clck);
        #1;
        check("hold_win", 32'(win), 32'd1);
        check("hold_winner", 32'(winner), 32'd1);
        check("hold_run_len", 32'(run_len), 32'd5);

        // Reset mid-scan aborts without a done pulse
        board = '0;
        set_cell(0, 0, 2'b10);
        go(0, 0, 1'b0, 1'b0, 2'b00, 4'd0, 0);
        repeat (4) @(posedge Clck);
        #1;
        Reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_run_len", 32'(run_len), 32'd0);
        repeat (2) @(posedge Clck);
        #1;
        Reset = 1'b0;
        repeat (20) @(posedge Clck);
        #1;
        check("abort_busy_after", 32'(busy), 32'd0);
        check("pending_results", sbq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
